// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 Hz porch/sync values,
// derived totals, counter width and the idle levels of the sync/blank signals.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int PIPE_DELAY_DEF = 1;

    // Both counters are 10 bits, so a total of up to 1024 is representable.
    localparam int CNT_W     = 10;
    localparam int TOTAL_MAX = 1 << CNT_W;

    localparam logic SYNC_INACTIVE = 1'b1;
    localparam logic VIS_INACTIVE  = 1'b0;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_TICK = 1'b1
    } phase_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam sync_t SYNC_IDLE = '{hs: SYNC_INACTIVE, vs: SYNC_INACTIVE, vis: VIS_INACTIVE};

    function automatic int span_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_out_if.sv
// Pixel-source bus: raw scan coordinates and tick/strobe pulses out of the
// timing block, RGB for those coordinates back from the pixel source.
interface vga_timing_out_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             pix_en;
    logic             line_start;
    logic             frame_start;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;

    modport master (
        output x, y, pix_en, line_start, frame_start,
        input  red, green, blue
    );

    modport slave (
        input  x, y, pix_en, line_start, frame_start,
        output red, green, blue
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Enabled shift register carrying hsync/vsync/visible alongside the pixel
// source latency; every stage resets to the inactive levels.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  en,
    input  sync_t din,
    output sync_t tap,
    output sync_t dout
);

    sync_t stage_q [DEPTH];

    // NOTE: every stage is reset, not just the last one: a stale hs/vs/vis in a
    // middle stage would reach the pins after reset release.
    // NOTE: sequential state uses non-blocking assignments so each stage
    // captures its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // tap is the value the last stage loads next, so RGB gated by tap.vis
    // lands on the pins in the same edge as the matching blank/syncs.
    if (DEPTH == 1) begin : g_tap_direct
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = stage_q[DEPTH-2];
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing and pin stage: 25 MHz pixel tick from the 50 MHz clock, raw x/y
// scan counters, delayed syncs/blank and blanked RGB registers on the pins.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_timing_out_if.master  pix,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              vga_clk
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > TOTAL_MAX || V_TOTAL > TOTAL_MAX) begin : g_bad_total
        $error("vga_timing_out: H_TOTAL/V_TOTAL exceed the counter range");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_out: PIPE_DELAY must be within 1..4");
    end

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    rgb_t             rgb_q, rgb_d;
    logic             pix_en;
    sync_t            raw;
    sync_t            tap;
    sync_t            dly;

    assign pix_en = (phase_q == PH_TICK);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        phase_d       = (phase_q == PH_TICK) ? PH_IDLE : PH_TICK;
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        rgb_d         = rgb_q;

        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d          = '0;
                line_start_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end

            // Blanking forces black regardless of what the pixel source returns.
            if (tap.vis) begin
                rgb_d = '{r: pix.red, g: pix.green, b: pix.blue};
            end else begin
                rgb_d = '0;
            end
        end
    end

    always_comb begin
        raw     = SYNC_IDLE;
        raw.hs  = !((h_q >= HS_START) && (h_q < HS_END));
        raw.vs  = !((v_q >= VS_START) && (v_q < VS_END));
        raw.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= PH_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            phase_q       <= phase_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    // The last delay stage doubles as the sync/blank pin register.
    vga_sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_en),
        .din     (raw),
        .tap     (tap),
        .dout    (dly)
    );

    assign pix.x           = h_q;
    assign pix.y           = v_q;
    assign pix.pix_en      = pix_en;
    assign pix.line_start  = line_start_q;
    assign pix.frame_start = frame_start_q;

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = dly.hs;
    assign vga_vs      = dly.vs;
    assign vga_blank_n = dly.vis;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = (phase_q == PH_TICK);

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a full-size instance (PIPE_DELAY=1) and a shrunken
// instance (PIPE_DELAY=2) checked every clock against a scoreboard model.
module tb_vga_timing_out;

    typedef struct packed {
        logic       ls;
        logic       fs;
        logic       pix;
        logic       vclk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       sync_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pins_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    localparam int HT  [2] = '{800, 32};
    localparam int VT  [2] = '{525, 15};
    localparam int HV  [2] = '{640, 16};
    localparam int VV  [2] = '{480, 8};
    localparam int HSS [2] = '{656, 20};
    localparam int HSE [2] = '{752, 26};
    localparam int VSS [2] = '{490, 10};
    localparam int VSE [2] = '{492, 12};
    localparam int PD  [2] = '{1, 2};

    localparam pins_t RESET_VEC = '{ls: 1'b0, fs: 1'b0, pix: 1'b0, vclk: 1'b0,
                                    x: '0, y: '0, hs: 1'b1, vs: 1'b1, bn: 1'b0,
                                    sync_n: 1'b0, r: '0, g: '0, b: '0};
    localparam px_t PX_IDLE = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: '0, g: '0, b: '0};

    logic       clk;
    logic [1:0] rst_n;

    vga_timing_out_if ifa ();
    vga_timing_out_if ifb ();

    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, a_bn, a_sn, a_vclk;
    logic       b_hs, b_vs, b_bn, b_sn, b_vclk;

    vga_timing_out u_dut_a (
        .clk         (clk),
        .reset_n     (rst_n[0]),
        .pix         (ifa),
        .vga_r       (a_r),
        .vga_g       (a_g),
        .vga_b       (a_b),
        .vga_hs      (a_hs),
        .vga_vs      (a_vs),
        .vga_blank_n (a_bn),
        .vga_sync_n  (a_sn),
        .vga_clk     (a_vclk)
    );

    vga_timing_out #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
        .V_VISIBLE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .PIPE_DELAY (2)
    ) u_dut_b (
        .clk         (clk),
        .reset_n     (rst_n[1]),
        .pix         (ifb),
        .vga_r       (b_r),
        .vga_g       (b_g),
        .vga_b       (b_b),
        .vga_hs      (b_hs),
        .vga_vs      (b_vs),
        .vga_blank_n (b_bn),
        .vga_sync_n  (b_sn),
        .vga_clk     (b_vclk)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Pixel sources: red = x, green = y, blue = constant FF; latency is
    // 2*PIPE_DELAY-1 clocks so the RGB arrives just before the pin register loads.
    logic [7:0] src_a_r, src_a_g;
    logic [7:0] src_b_r [3];
    logic [7:0] src_b_g [3];

    always @(posedge clk) begin
        src_a_r    <= ifa.x[7:0];
        src_a_g    <= ifa.y[7:0];
        src_b_r[0] <= ifb.x[7:0];
        src_b_r[1] <= src_b_r[0];
        src_b_r[2] <= src_b_r[1];
        src_b_g[0] <= ifb.y[7:0];
        src_b_g[1] <= src_b_g[0];
        src_b_g[2] <= src_b_g[1];
    end

    assign ifa.red   = src_a_r;
    assign ifa.green = src_a_g;
    assign ifa.blue  = 8'hFF;
    assign ifb.red   = src_b_r[2];
    assign ifb.green = src_b_g[2];
    assign ifb.blue  = 8'hFF;

    pins_t obs [2];
    assign obs[0] = {ifa.line_start, ifa.frame_start, ifa.pix_en, a_vclk, ifa.x, ifa.y,
                     a_hs, a_vs, a_bn, a_sn, a_r, a_g, a_b};
    assign obs[1] = {ifb.line_start, ifb.frame_start, ifb.pix_en, b_vclk, ifb.x, ifb.y,
                     b_hs, b_vs, b_bn, b_sn, b_r, b_g, b_b};

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic px_t exp_px(input int d, input int h, input int v);
        px_t p;
        logic vis;
        vis  = (h < HV[d]) && (v < VV[d]);
        p.hs = !((h >= HSS[d]) && (h < HSE[d]));
        p.vs = !((v >= VSS[d]) && (v < VSE[d]));
        p.bn = vis;
        p.r  = vis ? 8'(h) : 8'h00;
        p.g  = vis ? 8'(v) : 8'h00;
        p.b  = vis ? 8'hFF : 8'h00;
        return p;
    endfunction

    // Reference model: counters, strobes and a scoreboard of expected pin values.
    int   m_h  [2];
    int   m_v  [2];
    logic m_ph [2];
    logic m_ls [2];
    logic m_fs [2];
    px_t  m_cur [2];
    px_t  sb_q [2][$];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_h[d]   = 0;
                m_v[d]   = 0;
                m_ph[d]  = 1'b0;
                m_ls[d]  = 1'b0;
                m_fs[d]  = 1'b0;
                m_cur[d] = PX_IDLE;
                sb_q[d].delete();
            end else begin
                m_ls[d] = 1'b0;
                m_fs[d] = 1'b0;
                if (m_ph[d]) begin
                    sb_q[d].push_back(exp_px(d, m_h[d], m_v[d]));
                    if (sb_q[d].size() == PD[d]) m_cur[d] = sb_q[d].pop_front();
                    if (m_h[d] == HT[d] - 1) begin
                        m_h[d]  = 0;
                        m_ls[d] = 1'b1;
                        if (m_v[d] == VT[d] - 1) begin
                            m_v[d]  = 0;
                            m_fs[d] = 1'b1;
                        end else begin
                            m_v[d] = m_v[d] + 1;
                        end
                    end else begin
                        m_h[d] = m_h[d] + 1;
                    end
                end
                m_ph[d] = !m_ph[d];
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pins_t e;
            if (!rst_n[d]) begin
                e = RESET_VEC;
            end else begin
                e = {m_ls[d], m_fs[d], m_ph[d], m_ph[d], 10'(m_h[d]), 10'(m_v[d]),
                     m_cur[d].hs, m_cur[d].vs, m_cur[d].bn, 1'b0,
                     m_cur[d].r, m_cur[d].g, m_cur[d].b};
            end
            check((d == 0) ? "pins_a" : "pins_b", obs[d], e);
        end
    end

    // Period and pulse-width monitors, measured in clk cycles.
    int a_gap = 0, a_hs_lo = 0, a_ls_n = 0;
    int b_gap = 0, b_vs_lo = 0, b_fs_n = 0;
    bit a_seen = 1'b0, b_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n[0]) begin
            a_seen = 1'b0; a_gap = 0; a_hs_lo = 0;
        end else begin
            a_gap++;
            if (ifa.line_start) begin
                if (a_seen) check("line_period", a_gap, 1600);
                a_seen = 1'b1; a_gap = 0; a_ls_n++;
            end
            if (!a_hs) a_hs_lo++;
            else if (a_hs_lo != 0) begin
                check("hs_width", a_hs_lo, 192);
                a_hs_lo = 0;
            end
        end
        if (!rst_n[1]) begin
            b_seen = 1'b0; b_gap = 0; b_vs_lo = 0;
        end else begin
            b_gap++;
            if (ifb.frame_start) begin
                if (b_seen) check("frame_period", b_gap, 960);
                b_seen = 1'b1; b_gap = 0; b_fs_n++;
            end
            if (!b_vs) b_vs_lo++;
            else if (b_vs_lo != 0) begin
                check("vs_width", b_vs_lo, 128);
                b_vs_lo = 0;
            end
        end
    end

    initial begin
        bit found;
        bit got_fs;
        int cnt;

        rst_n = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 2'b11;

        @(posedge clk);
        #1;
        check("pix_after_edge1", ifa.pix_en, 1);
        check("x_after_edge1", ifa.x, 0);
        @(posedge clk);
        #1;
        check("x_after_edge2", ifa.x, 1);
        check("pix_after_edge2", ifa.pix_en, 0);

        repeat (2100) @(posedge clk);

        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (ifb.x == 10'd10 && ifb.y == 10'd5) found = 1'b1;
        end
        check("reach_x10_y5", found, 1);

        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1 check("async_reset_b", obs[1], RESET_VEC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n[1] = 1'b1;

        cnt    = 0;
        got_fs = 1'b0;
        while (cnt < 2000 && !got_fs) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ifb.frame_start) got_fs = 1'b1;
        end
        check("restart_frame_period", cnt, 960);

        repeat (20) @(posedge clk);
        check("line_pulses_seen", a_ls_n >= 2, 1);
        check("frame_pulses_seen", b_fs_n >= 3, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
